// File: rtl/tt_uart_pkg.sv
// Shared types and pin maps for the TinyTapeout UART transmitter.
package tt_uart_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // uo_out bit positions
    localparam int unsigned UO_TX      = 0;
    localparam int unsigned UO_BUSY    = 1;
    localparam int unsigned UO_FULL    = 2;
    localparam int unsigned UO_EMPTY   = 3;
    localparam int unsigned UO_OVF     = 4;
    localparam int unsigned UO_CNT_LSB = 5;
    localparam int unsigned UO_CNT_W   = 3;

    // uio_in bit positions
    localparam int unsigned UIO_WR_STB = 0;
    localparam int unsigned UIO_PAR_EN = 1;

    // uo_out payload, MSB first so it maps straight onto the pins
    typedef struct packed {
        logic [UO_CNT_W-1:0] count;
        logic                overflow;
        logic                empty;
        logic                full;
        logic                busy;
        logic                tx;
    } uo_status_t;

    // Even parity bit for one data byte
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        do_push_c = push & ~full;
        do_pop_c  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/tt_um_uart_tx_fifo.sv
// TinyTapeout wrapper: byte FIFO feeding an 8N1/8E1 UART transmitter.
module tt_um_uart_tx_fifo
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              overflow_q, overflow_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_last_c;
    logic              wr_stb_c;
    logic              unused_uio_c;
    uo_status_t        status_c;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (ui_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write acceptance and sticky overflow; fullness is judged on the registered count
    always_comb begin
        wr_stb_c    = ena & uio_in[UIO_WR_STB];
        fifo_push_c = wr_stb_c & ~fifo_full;
        overflow_d  = overflow_q | (wr_stb_c & fifo_full);
    end

    // Transmit FSM: next state, baud/bit counters, shift register, pop request and tx level
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q + BAUD_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        fifo_pop_c  = 1'b0;
        baud_last_c = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    shift_d    = fifo_dout;
                    par_en_d   = uio_in[UIO_PAR_EN];
                    par_bit_d  = even_parity(fifo_dout);
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_last_c) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last_c) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_last_c) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap
                        fifo_pop_c = 1'b1;
                        shift_d    = fifo_dout;
                        par_en_d   = uio_in[UIO_PAR_EN];
                        par_bit_d  = even_parity(fifo_dout);
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // tx and busy are computed from the next state so the pins are pure flops
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // Pin mapping
    always_comb begin
        status_c.tx       = tx_q;
        status_c.busy     = busy_q;
        status_c.full     = fifo_full;
        status_c.empty    = fifo_empty;
        status_c.overflow = overflow_q;
        status_c.count    = UO_CNT_W'(fifo_count);
        uo_out            = status_c;
        uio_out           = 8'h00;
        uio_oe            = 8'h00;
        unused_uio_c      = ^uio_in[7:2];
    end

endmodule

// File: tb/tb_tt_um_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes tx and checks them.
module tb_tt_um_uart_tx_fifo;

    localparam int unsigned CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic tx, busy, full, empty, ovf;
    logic [2:0] cnt;
    assign tx    = uo_out[0];
    assign busy  = uo_out[1];
    assign full  = uo_out[2];
    assign empty = uo_out[3];
    assign ovf   = uo_out[4];
    assign cnt   = uo_out[7:5];

    exp_t exp_q[$];
    int   start_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   uio_bad = 0;
    bit   mon_busy = 1'b0;

    tt_um_uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) uio_bad <= uio_bad + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n < budget), 1);
    endtask

    // Line monitor: detect start bit, sample mid-bit, compare against the queue head
    initial begin : monitor
        exp_t       e;
        logic [7:0] d;
        logic       p, s, sb;
        bit         ab, has_par, have_exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                ab = 1'b0;
                start_q.push_back(cyc);
                have_exp = (exp_q.size() != 0);
                has_par  = have_exp ? exp_q[0].par_en : 1'b0;
                mon_wait(7, ab);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB, ab);
                    d[i] = tx;
                end
                p = 1'b0;
                if (has_par) begin
                    mon_wait(CPB, ab);
                    p = tx;
                end
                mon_wait(CPB, ab);
                s = tx;
                if (!ab) begin
                    chk("frame_expected", int'(have_exp), 1);
                    if (have_exp) begin
                        e = exp_q.pop_front();
                        chk("start_bit", int'(sb), 0);
                        chk("frame_data", int'(d), int'(e.data));
                        if (e.par_en) chk("parity_bit", int'(p), int'(e.par_bit));
                        chk("stop_bit", int'(s), 1);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin : stim
        int n, lo, gap, good, bad;
        int ovf_cnt[6] = '{1, 1, 2, 3, 4, 4};

        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_uo_out", int'(uo_out), 'h09);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte, parity off; toggling parity enable mid-frame must not matter
        start_q.delete();
        exp_q.push_back('{8'hA5, 1'b0, 1'b0});
        ui_in  = 8'hA5;
        uio_in = 8'h01;
        @(negedge clk);
        uio_in = 8'h00;
        chk("t1_count_after_E0", int'(cnt), 1);
        chk("t1_busy_after_E0", int'(busy), 0);
        @(negedge clk);
        chk("t1_tx_after_E1", int'(tx), 0);
        chk("t1_busy_after_E1", int'(busy), 1);
        chk("t1_count_after_E1", int'(cnt), 0);
        n = 0;
        lo = 0;
        while (busy === 1'b1 && n < 400) begin
            if (tx === 1'b0 && lo == n) lo++;
            n++;
            if (n == 40)  uio_in = 8'h02;
            if (n == 120) uio_in = 8'h00;
            @(negedge clk);
        end
        chk("t1_start_len", lo, 16);
        chk("t1_busy_cycles", n, 160);
        chk("t1_empty_after", int'(empty), 1);
        wait_idle("t1_idle", 100);

        // Parity on, two back-to-back frames
        start_q.delete();
        exp_q.push_back('{8'hA5, 1'b1, 1'b0});
        exp_q.push_back('{8'h07, 1'b1, 1'b1});
        ui_in  = 8'hA5;
        uio_in = 8'h03;
        @(negedge clk);
        ui_in = 8'h07;
        @(negedge clk);
        uio_in = 8'h02;
        chk("t2_count_push_pop", int'(cnt), 1);
        wait_idle("t2_idle", 800);
        uio_in = 8'h00;
        chk("t2_frames", start_q.size(), 2);
        gap = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
        chk("t2_back_to_back_gap", gap, 11 * CPB);

        // Overflow: six strobes, sixth dropped
        start_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back('{8'(i), 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) begin
            ui_in  = 8'(i + 1);
            uio_in = 8'h01;
            @(negedge clk);
            chk($sformatf("t3_count_edge%0d", i + 1), int'(cnt), ovf_cnt[i]);
        end
        uio_in = 8'h00;
        chk("t3_full", int'(full), 1);
        chk("t3_overflow", int'(ovf), 1);
        wait_idle("t3_idle", 1500);
        chk("t3_frames", start_q.size(), 5);
        good = 0;
        for (int k = 1; k < start_q.size(); k++) if (start_q[k] - start_q[k-1] == 10 * CPB) good++;
        chk("t3_gaps", good, 4);
        chk("t3_empty_after", int'(empty), 1);
        chk("t3_overflow_sticky", int'(ovf), 1);

        // ena low: strobe ignored
        ena    = 1'b0;
        ui_in  = 8'h3C;
        uio_in = 8'h01;
        @(negedge clk);
        uio_in = 8'h00;
        chk("t4_count", int'(cnt), 0);
        repeat (3) @(negedge clk);
        chk("t4_tx", int'(tx), 1);
        chk("t4_busy", int'(busy), 0);
        ena = 1'b1;

        // Reset in the middle of a 0xFF frame with two bytes queued
        exp_q.push_back('{8'hFF, 1'b0, 1'b0});
        ui_in  = 8'hFF;
        uio_in = 8'h01;
        @(negedge clk);
        ui_in = 8'hAA;
        @(negedge clk);
        ui_in = 8'h55;
        @(negedge clk);
        uio_in = 8'h00;
        chk("t5_count_queued", int'(cnt), 2);
        repeat (30) @(negedge clk);
        chk("t5_busy_mid_data", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_tx_in_reset", int'(tx), 1);
        chk("t5_count_in_reset", int'(cnt), 0);
        chk("t5_empty_in_reset", int'(empty), 1);
        chk("t5_overflow_in_reset", int'(ovf), 0);
        chk("t5_busy_in_reset", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("t5_no_frame_after_reset", bad, 0);

        wait_idle("final_idle", 400);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("uio_zero", uio_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_uart_tx_fifo.md
# tt_um_uart_tx_fifo

Byte-to-serial UART transmitter behind the standard TinyTapeout user-project pin interface; it is the device end that the cocotb bench drives through `ui_in`/`uio_in` and observes on `uo_out`. Bytes presented on `ui_in` with a write strobe are queued in a 4-entry FIFO and shifted out LSB-first as 8N1 or 8E1 frames on `uo_out[0]`. FIFO and transmitter status are exported on the remaining `uo_out` pins.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  design selected; when low, writes are ignored and an in-flight frame completes.
- `ui_in`  in  8  write data byte.
- `uio_in`  in  8  `[0]` write strobe, `[1]` parity enable; `[7:2]` unused.
- `uo_out`  out  8  `[0]` tx, `[1]` busy, `[2]` full, `[3]` empty, `[4]` overflow, `[7:5]` FIFO count.
- `uio_out`  out  8  constant 0.
- `uio_oe`  out  8  constant 0; all bidirectional pins are inputs.

## Operation
- Reset values: tx=1, busy=0, full=0, empty=1, overflow=0, count=0, FSM=IDLE.
- Write:
  - Accepted on every edge where `ena`=1, `uio_in[0]`=1 and the registered count < `FIFO_DEPTH`.
  - A strobe while full drops the byte and sets overflow. Overflow is sticky until reset.
  - Full is judged on the registered count, so a write arriving while full is rejected even if a pop occurs on the same edge.
- Simultaneous accepted write and pop: both take effect and the count is unchanged.
- FSM states:
  - IDLE: tx=1. On an edge with the FIFO non-empty, pop the head into the shift register, latch parity enable from `uio_in[1]`, and go to START.
  - START: tx=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, `CLKS_PER_BIT` cycles each. The bit index is 3 bits and wraps 7→0 on exit. Go to PARITY if parity enable was latched, otherwise to STOP.
  - PARITY: tx = XOR of the data byte (even parity), for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: tx=1 for `CLKS_PER_BIT` cycles. On its last cycle:
    - FIFO non-empty: pop and go directly to START. Back-to-back frames have no idle gap.
    - FIFO empty: go to IDLE.
- busy = FSM ≠ IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and reloads 0 on every state or bit change.
- `uio_in[1]` changes mid-frame do not affect the frame in flight.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the FIFO empties, and the partial frame is abandoned.

## Timing
- tx, busy and all status bits are registered outputs with no combinational path from inputs.
- Write accepted at edge E0 into an empty FIFO while IDLE:
  - count=1 after E0.
  - Pop at E1; tx=0 and busy=1 from E1.
  - Count returns to 0 after E1.
- Frame length is 10×`CLKS_PER_BIT` cycles without parity, 11× with parity.
- busy falls on the edge that ends STOP when the FIFO is empty.
- Status pins reflect the count after the current edge, with one-cycle latency from the strobe.

## Structure
- Package `tt_uart_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP), `uo_out` bit-index localparams, `uio_in` bit-index localparams.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO with `push`, `pop`, `din`, `dout`, `count`, `full`, `empty`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Count width is `$clog2(FIFO_DEPTH)+1`.
- Top level holds the FSM, baud counter, shift register, parity latch, overflow flag, and pin mapping.

## Test plan
- Single byte, `CLKS_PER_BIT`=16, parity off: write 0xA5.
  - tx low 16 cycles from E1, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then stop high.
  - busy high for exactly 160 cycles; empty=1 afterwards.
- Parity on: write 0xA5, then 0x07.
  - The 11th bit is 0 for 0xA5 and 1 for 0x07.
  - Frames are back-to-back: the second start bit begins on the cycle after the first stop bit ends.
- Overflow: six consecutive strobes with data 0x01..0x06 while idle.
  - Count after each edge: 1,1,2,3,4; the 6th write is rejected.
  - full=1 and overflow=1; the transmitted sequence is 0x01..0x05.
- `ena`=0 with a strobe and data 0x3C: count stays 0, tx stays 1, busy stays 0.
- Reset asserted mid-DATA of 0xFF with 2 bytes queued:
  - tx=1, count=0, empty=1, overflow=0 before the next clock edge.
  - No frame starts after reset is released.
- `uio_oe` and `uio_out` read 0x00 throughout all scenarios.
